// File: rtl/vdp_vram_write_fifo_if.sv
// Host/arbiter bundle for the VRAM write FIFO.
// The FIFO side uses the slave modport. The host and arbiter side uses master.
interface vdp_vram_write_fifo_if #(
  parameter int COUNT_WIDTH = 5
);
  logic                   host_address_write;
  logic [14:0]            host_address;
  logic                   host_increment_write;
  logic [7:0]             host_increment;
  logic                   host_data_write;
  logic [15:0]            host_data;
  logic                   host_clear_overflow;
  logic                   vram_written;
  logic [13:0]            vram_write_address_16b;
  logic [15:0]            vram_write_data_16b;
  logic [1:0]             vram_port_write_en_mask;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [COUNT_WIDTH-1:0] fifo_count;
  logic                   overflow;

  modport master (
    output host_address_write, host_address, host_increment_write, host_increment,
           host_data_write, host_data, host_clear_overflow, vram_written,
    input  vram_write_address_16b, vram_write_data_16b, vram_port_write_en_mask,
           fifo_empty, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  host_address_write, host_address, host_increment_write, host_increment,
           host_data_write, host_data, host_clear_overflow, vram_written,
    output vram_write_address_16b, vram_write_data_16b, vram_port_write_en_mask,
           fifo_empty, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/vdp_vram_write_fifo.sv
// Host-side VRAM write buffer.
// CPU writes are queued as {cursor, data} entries behind an auto-incrementing
// word cursor. The head entry is presented show-ahead to the arbiter write slot
// and is retired on each vram_written strobe.
module vdp_vram_write_fifo #(
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  vdp_vram_write_fifo_if.slave   io_bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 31;  // {addr[14:1], bank, data[15:0]}

  logic [14:0]            r_cursor;
  logic [7:0]             r_increment;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_overflow;
  logic [ENTRY_W-1:0]     r_mem [DEPTH];
  // Copy of the most recently retired entry. While empty it drives the bus so
  // the address/data lines keep the last-read contents. The read pointer slot
  // may hold stale data from an earlier lap, so it cannot be used here.
  logic [ENTRY_W-1:0]     r_last;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [ENTRY_W-1:0]     w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == COUNT_WIDTH'(DEPTH));
  assign w_pop   = io_bus.vram_written & ~w_empty;
  // A full FIFO still accepts a push when the head retires on the same edge.
  assign w_push  = io_bus.host_data_write & (~w_full | w_pop);
  assign w_drop  = io_bus.host_data_write & ~w_push;
  assign w_head  = w_empty ? r_last : r_mem[r_rd_ptr];

  assign io_bus.vram_write_address_16b  = w_head[30:17];
  assign io_bus.vram_write_data_16b     = w_head[15:0];
  assign io_bus.vram_port_write_en_mask = w_empty ? 2'b00 : (w_head[16] ? 2'b10 : 2'b01);
  assign io_bus.fifo_empty              = w_empty;
  assign io_bus.fifo_full               = w_full;
  assign io_bus.fifo_count              = r_count;
  assign io_bus.overflow                = r_overflow;

  // Entry storage. Every entry is written before it is read, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_cursor, io_bus.host_data};
  end

  // Cursor and increment. An address load overrides the post-increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cursor    <= '0;
      r_increment <= 8'd1;
    end else begin
      if (io_bus.host_address_write)   r_cursor <= io_bus.host_address;
      else if (io_bus.host_data_write) r_cursor <= r_cursor + {7'd0, r_increment};
      if (io_bus.host_increment_write) r_increment <= io_bus.host_increment;
    end
  end

  // Pointers, occupancy count and last-read copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
        2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow. A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_overflow <= 1'b0;
    else if (w_drop)                     r_overflow <= 1'b1;
    else if (io_bus.host_clear_overflow) r_overflow <= 1'b0;
  end
endmodule

// File: doc/vdp_vram_write_fifo.md
Name: vdp_vram_write_fifo

Overview:
- Host-side VRAM write buffer that sits directly upstream of the standard VRAM bus arbiter.
- Accepts CPU VRAM writes at arbitrary rate. Auto-increments a 15-bit word cursor.
- Queues {address, data} entries and presents the head entry to the arbiter's write slot.
- Retires the head entry on the arbiter's vram_written strobe, which occurs once every 8 cycles.

Parameters:
- DEPTH, 16, number of FIFO entries. Power of two, minimum 2.
- COUNT_WIDTH, 5, width of the occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- host_address_write  input  1  load the write cursor from host_address
- host_address  input  15  new cursor value (16-bit word address)
- host_increment_write  input  1  load the increment register from host_increment
- host_increment  input  8  cursor post-increment, in words
- host_data_write  input  1  push host_data at the current cursor
- host_data  input  16  write data
- host_clear_overflow  input  1  clear the sticky overflow flag
- vram_written  input  1  arbiter write-slot strobe (slot 0 of each 8-cycle group)
- vram_write_address_16b  output  14  head entry address bits [14:1]
- vram_write_data_16b  output  16  head entry data
- vram_port_write_en_mask  output  2  head bank enable: 2'b01 even, 2'b10 odd, 2'b00 empty
- fifo_empty  output  1  no entries queued
- fifo_full  output  1  count == DEPTH
- fifo_count  output  COUNT_WIDTH  current occupancy
- overflow  output  1  sticky flag: a push was dropped

Behaviour:
- Reset (async, active-high):
  - cursor=0, increment=1, read/write pointers=0, count=0, overflow=0.
  - Outputs: fifo_empty=1, fifo_full=0, mask=0, address=0, data=0.
- Cursor:
  - On host_data_write, the entry captures the current cursor.
  - The cursor then advances by the zero-extended increment, mod 2^15; wraps 0x7FFF+1 to 0x0000.
  - If host_address_write coincides with host_data_write:
    - the pushed entry uses the old cursor;
    - the cursor loads host_address, with no increment applied.
  - host_increment_write takes effect from the next push. An increment of 0 is legal and repeats the address.
- Entry format: {cursor[14:1], cursor[0], data}.
- Head presentation (show-ahead):
  - Outputs come combinationally from the storage entry at the read pointer.
  - vram_port_write_en_mask = empty ? 2'b00 : (bank ? 2'b10 : 2'b01).
  - When empty, address and data hold the last-read entry contents. The arbiter ignores them because the mask is 0.
  - Outputs must be stable for the whole cycle in which vram_written=1; the arbiter registers them on that edge.
- Pop:
  - On a rising edge with vram_written=1 and !empty: advance the read pointer, count-1.
  - vram_written while empty has no effect.
- Push:
  - Accepted when count<DEPTH, or when a pop occurs in the same cycle.
  - If full and no pop: the entry is dropped, the cursor still advances, and overflow is set.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - When empty, a push is visible on the outputs the cycle after the push edge. There is no same-cycle bypass.
- Overflow:
  - Sticky until host_clear_overflow.
  - If clear and a drop occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH.
- fifo_full, fifo_empty and fifo_count are derived from the count register.
- Throughput: at most one retire per 8 cycles, as paced by the arbiter.
- Latency: push at edge N → head visible from N+1 → retired on the first vram_written edge at or after N+1.

Test Plan:
- Reset, address=0x1235, inc=1, push 0xAAAA, 0xBBBB, then wait for vram_written strobes:
  - first retire: addr 0x091A, mask 2'b10, data 0xAAAA;
  - second retire: addr 0x091B, mask 2'b01, data 0xBBBB;
  - afterwards fifo_empty=1 and mask=0.
- Cursor wrap: address=0x7FFF, inc=2, push 2 words → entries at word addresses 0x7FFF then 0x0001.
- Fill with 16 pushes and no strobes → fifo_full=1, count=16. A 17th push sets overflow=1, count stays 16, and the cursor has advanced 17 times.
- Full FIFO with push and vram_written in the same cycle → push accepted, count stays 16, overflow stays 0.
- Concurrent events, with the cursor at 0x0010:
  - host_address_write=0x0100 coincides with host_data_write → entry at 0x0010, cursor becomes 0x0100;
  - host_clear_overflow coincides with a dropped push → overflow=1.
- Assert reset mid-stream with 5 entries queued → all outputs return to reset values immediately (async), and the next strobe does nothing.
